// File: rtl/keccak_pkg.sv
// Shared Keccak load-stage types: hash modes, rate lookup, padding constants
// and the record held per completed block.
package keccak_pkg;

    typedef enum logic [1:0] {
        SHAKE128 = 2'd0,
        SHAKE256 = 2'd1,
        SHA3_256 = 2'd2,
        SHA3_512 = 2'd3
    } mode_t;

    localparam int         RATE_MAX  = 1344;
    localparam logic [7:0] PAD_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_SHA3  = 8'h06;
    localparam logic [7:0] PAD_END   = 8'h80;

    typedef struct packed {
        logic [RATE_MAX-1:0] blk;
        logic                last;
        mode_t               mode;
        logic [31:0]         osize;
    } blk_entry_t;

    function automatic int rate_bits(input mode_t m);
        case (m)
            SHAKE128: return 1344;
            SHA3_512: return 576;
            default:  return 1088;
        endcase
    endfunction

    function automatic logic [7:0] pad_domain(input mode_t m);
        return (m == SHAKE128 || m == SHAKE256) ? PAD_SHAKE : PAD_SHA3;
    endfunction

endpackage

// File: rtl/load_block_fifo.sv
// NBUF-deep queue of completed blocks; the head entry reads as zero when empty.
module load_block_fifo
    import keccak_pkg::*;
#(
    parameter int NBUF = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  blk_entry_t i_entry,
    input  logic       i_pop,
    output blk_entry_t o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int PW = (NBUF > 1) ? $clog2(NBUF) : 1;
    localparam int CW = $clog2(NBUF + 1);

    blk_entry_t      r_mem [NBUF];
    logic [PW-1:0]   r_rd;
    logic [PW-1:0]   r_wr;
    logic [CW-1:0]   r_cnt;
    logic            w_do_pop;
    logic            w_do_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NBUF - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_cnt == CW'(NBUF));
    assign o_empty   = (r_cnt == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full queue is only taken when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = o_empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= ptr_inc(r_wr);
            end
            if (w_do_pop) begin
                r_rd <= ptr_inc(r_rd);
            end
            if (w_do_push && !w_do_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/load_stage_multimode.sv
// Absorbs header + message words, assembles rate-sized blocks per hash mode,
// applies pad10*1 with the mode's domain byte and queues blocks for the permutation.
module load_stage_multimode
    import keccak_pkg::*;
#(
    parameter int W     = 64,
    parameter int NBUF  = 2,
    parameter int LEN_W = 30
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [W-1:0]        data_in,
    output logic                ready_out,
    output logic [RATE_MAX-1:0] blk_data,
    output logic                blk_valid,
    input  logic                blk_ready,
    output logic                blk_last,
    output mode_t               operation_mode,
    output logic [31:0]         output_size
);

    localparam int WB  = W / 8;
    localparam int WCW = $clog2(RATE_MAX / W);

    typedef enum logic [1:0] {S_HDR, S_LOAD, S_PAD} state_t;

    state_t              r_state;
    logic                r_run;
    mode_t               r_mode;
    logic [LEN_W-1:0]    r_rem;
    logic [31:0]         r_osize;
    logic [WCW-1:0]      r_wcnt;
    logic [RATE_MAX-1:0] r_blk;
    logic [7:0]          r_pad_off;

    logic [63:0]         w_hdr;
    logic                w_hdr_done;
    logic [LEN_W-1:0]    w_len;
    logic [W-1:0]        w_word;
    logic [RATE_MAX-1:0] w_blk_ins;
    logic [RATE_MAX-1:0] w_pad_blk;
    logic [LEN_W-1:0]    w_take;
    logic [7:0]          w_dom;
    int                  w_rbytes;
    int                  w_nwords;
    logic                w_last_word;
    logic                w_fills;
    logic                w_accept;
    logic                w_pop;
    logic                w_pad_go;
    logic                w_push;
    logic                w_full;
    logic                w_empty;
    blk_entry_t          w_entry;
    blk_entry_t          w_head;

    genvar gi;

    // A 64-bit header arrives either whole or as two halves, low half first.
    generate
        if (W == 64) begin : g_hdr64
            assign w_hdr      = data_in;
            assign w_hdr_done = 1'b1;
        end else begin : g_hdr32
            logic        r_half;
            logic [31:0] r_lo;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_half <= 1'b0;
                    r_lo   <= '0;
                end else if (r_state == S_HDR && w_accept) begin
                    r_half <= ~r_half;
                    if (!r_half) begin
                        r_lo <= data_in;
                    end
                end
            end
            assign w_hdr      = {data_in, r_lo};
            assign w_hdr_done = r_half;
        end
    endgenerate

    assign w_len       = w_hdr[32 +: LEN_W];
    assign w_dom       = pad_domain(r_mode);
    assign w_last_word = (r_rem <= LEN_W'(WB));
    assign w_take      = w_last_word ? r_rem : LEN_W'(WB);
    // Only a word that leaves the block holding a full rate of bytes pushes it;
    // a short final word in the last slot is padded in place instead.
    assign w_fills     = (int'(r_wcnt) == w_nwords - 1) && (r_rem >= LEN_W'(WB));
    assign w_accept    = valid_in && ready_out;
    assign w_pop       = blk_valid && blk_ready;
    assign w_pad_go    = (r_state == S_PAD) && (!w_full || w_pop);
    assign w_push      = (r_state == S_LOAD && w_accept && w_fills) || w_pad_go;

    always_comb begin
        w_rbytes = rate_bits(r_mode) / 8;
        w_nwords = rate_bits(r_mode) / W;
    end

    generate
        for (gi = 0; gi < WB; gi++) begin : g_mask
            assign w_word[8*gi +: 8] = (LEN_W'(gi) < r_rem) ? data_in[8*gi +: 8] : 8'h00;
        end
        for (gi = 0; gi < RATE_MAX / 8; gi++) begin : g_pad
            assign w_pad_blk[8*gi +: 8] = r_blk[8*gi +: 8]
                                        ^ ((r_pad_off == 8'(gi)) ? w_dom : 8'h00)
                                        ^ ((gi == w_rbytes - 1) ? PAD_END : 8'h00);
        end
    endgenerate

    always_comb begin
        w_blk_ins = r_blk;
        w_blk_ins[int'(r_wcnt) * W +: W] = w_word;
    end

    always_comb begin
        ready_out = 1'b0;
        if (r_run) begin
            case (r_state)
                S_HDR:   ready_out = 1'b1;
                S_LOAD:  ready_out = !(w_full && w_fills);
                default: ready_out = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_entry.blk   = (r_state == S_PAD) ? w_pad_blk : w_blk_ins;
        w_entry.last  = (r_state == S_PAD);
        w_entry.mode  = r_mode;
        w_entry.osize = r_osize;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_HDR;
            r_run     <= 1'b0;
            r_mode    <= SHAKE128;
            r_rem     <= '0;
            r_osize   <= '0;
            r_wcnt    <= '0;
            r_blk     <= '0;
            r_pad_off <= '0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                S_HDR: begin
                    if (w_accept && w_hdr_done) begin
                        r_mode    <= mode_t'(w_hdr[63:62]);
                        r_rem     <= w_len;
                        r_osize   <= w_hdr[31:0];
                        r_wcnt    <= '0;
                        r_blk     <= '0;
                        r_pad_off <= '0;
                        r_state   <= (w_len == '0) ? S_PAD : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_rem <= r_rem - w_take;
                        if (w_fills) begin
                            r_blk  <= '0;
                            r_wcnt <= '0;
                        end else begin
                            r_blk  <= w_blk_ins;
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                        if (w_last_word) begin
                            r_state   <= S_PAD;
                            r_pad_off <= w_fills ? 8'd0 : 8'(int'(r_wcnt) * WB + int'(w_take));
                        end
                    end
                end
                S_PAD: begin
                    if (w_pad_go) begin
                        r_blk   <= '0;
                        r_wcnt  <= '0;
                        r_state <= S_HDR;
                    end
                end
                default: r_state <= S_HDR;
            endcase
        end
    end

    load_block_fifo #(.NBUF(NBUF)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign blk_valid      = !w_empty;
    assign blk_data       = w_head.blk;
    assign blk_last       = w_head.last;
    assign operation_mode = w_head.mode;
    assign output_size    = w_head.osize;

endmodule

// File: tb/tb_load_stage_multimode.sv
// Directed bench for the multimode load stage: a W=64 and a W=32 instance, a vector
// table checked against a byte-level padding model, plus backpressure and reset sequences.
module tb_load_stage_multimode;

    typedef struct {
        bit          w32;
        logic [1:0]  mode;
        int          len;
        logic [31:0] os;
        int          rb;
        int          nblk;
        int          dom_off;
        logic [7:0]  dom;
    } vec_t;

    typedef struct packed {
        logic [1343:0] data;
        logic          last;
        logic [1:0]    mode;
        logic [31:0]   os;
    } cap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          v64 = 1'b0, r64, bv64, br64 = 1'b1, bl64;
    logic [63:0]   d64 = '0;
    logic [1343:0] bd64;
    logic [1:0]    m64;
    logic [31:0]   os64;

    logic          v32 = 1'b0, r32, bv32, br32 = 1'b1, bl32;
    logic [31:0]   d32 = '0;
    logic [1343:0] bd32;
    logic [1:0]    m32;
    logic [31:0]   os32;

    int   n_checks = 0;
    int   n_fail   = 0;
    cap_t q64[$];
    cap_t q32[$];
    vec_t vecs[11];
    vec_t bp;
    vec_t rv;

    load_stage_multimode #(.W(64), .NBUF(2), .LEN_W(30)) dut64 (
        .clk(clk), .rst(rst), .valid_in(v64), .data_in(d64), .ready_out(r64),
        .blk_data(bd64), .blk_valid(bv64), .blk_ready(br64), .blk_last(bl64),
        .operation_mode(m64), .output_size(os64)
    );

    load_stage_multimode #(.W(32), .NBUF(2), .LEN_W(30)) dut32 (
        .clk(clk), .rst(rst), .valid_in(v32), .data_in(d32), .ready_out(r32),
        .blk_data(bd32), .blk_valid(bv32), .blk_ready(br32), .blk_last(bl32),
        .operation_mode(m32), .output_size(os32)
    );

    // Pops are taken at the next rising edge; record them mid-cycle.
    always begin
        @(negedge clk);
        #1;
        if (bv64 && br64) q64.push_back({bd64, bl64, m64, os64});
        if (bv32 && br32) q32.push_back({bd32, bl32, m32, os32});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic chk_blk(input string name, input logic [1343:0] act, input logic [1343:0] exp);
        int bad;
        n_checks++;
        bad = -1;
        for (int p = 167; p >= 0; p--) if (act[8*p +: 8] !== exp[8*p +: 8]) bad = p;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: byte %0d got %02h expected %02h", name, bad,
                     act[8*bad +: 8], exp[8*bad +: 8]);
        end else begin
            $display("ok   %s", name);
        end
    endtask

    function automatic logic [7:0] msg_byte(input int n);
        return 8'((n * 29 + 5) % 256);
    endfunction

    function automatic logic [63:0] make_word(input vec_t v, input int k);
        logic [63:0] w;
        int wb;
        int n;
        wb = v.w32 ? 4 : 8;
        w  = '0;
        for (int j = 0; j < wb; j++) begin
            n = k * wb + j;
            w[8*j +: 8] = (n < v.len) ? msg_byte(n) : 8'hFF;
        end
        return w;
    endfunction

    task automatic put_word(input bit w32, input logic [63:0] w);
        int n;
        n = 0;
        @(negedge clk);
        if (w32) begin
            v32 = 1'b1;
            d32 = w[31:0];
        end else begin
            v64 = 1'b1;
            d64 = w;
        end
        #1;
        while (!(w32 ? r32 : r64) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL put_word timeout: ready_out stayed 0 for %0d cycles", n);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        v64 = 1'b0;
        v32 = 1'b0;
    endtask

    task automatic send_hdr(input vec_t v);
        logic [63:0] h;
        h = {v.mode, 30'(v.len), v.os};
        if (v.w32) begin
            put_word(1'b1, {32'h0, h[31:0]});
            put_word(1'b1, {32'h0, h[63:32]});
        end else begin
            put_word(1'b0, h);
        end
    endtask

    task automatic send_msg(input vec_t v);
        int nw;
        nw = (v.len + (v.w32 ? 3 : 7)) / (v.w32 ? 4 : 8);
        send_hdr(v);
        for (int k = 0; k < nw; k++) put_word(v.w32, make_word(v, k));
    endtask

    task automatic check_msg(input vec_t v, input string tag, input int base, input int total);
        cap_t          c;
        logic [1343:0] e;
        logic [7:0]    b;
        int            idx;
        int            sz;
        int            n;
        n = 0;
        sz = v.w32 ? q32.size() : q64.size();
        while (sz < base + v.nblk && n < 400) begin
            @(negedge clk);
            #2;
            n++;
            sz = v.w32 ? q32.size() : q64.size();
        end
        repeat (3) @(negedge clk);
        #2;
        sz = v.w32 ? q32.size() : q64.size();
        chk({tag, " block count"}, sz, total);
        for (int k = 0; k < v.nblk && base + k < sz; k++) begin
            c = v.w32 ? q32[base + k] : q64[base + k];
            e = '0;
            for (int p = 0; p < 168; p++) begin
                idx = k * v.rb + p;
                b = (p < v.rb && idx < v.len) ? msg_byte(idx) : 8'h00;
                if (k == v.nblk - 1) begin
                    if (p == v.dom_off) b = b ^ v.dom;
                    if (p == v.rb - 1)  b = b ^ 8'h80;
                end
                e[8*p +: 8] = b;
            end
            chk_blk($sformatf("%s blk%0d data", tag, k), c.data, e);
            chk($sformatf("%s blk%0d last", tag, k), c.last, (k == v.nblk - 1));
            chk($sformatf("%s blk%0d mode", tag, k), c.mode, v.mode);
            chk($sformatf("%s blk%0d output_size", tag, k), c.os, v.os);
        end
    endtask

    initial begin
        //            w32  mode   len  os      rb   nblk off  dom
        vecs[0]  = '{1'b0, 2'd0,   0, 32'd256, 168, 1,   0,   8'h1F};
        vecs[1]  = '{1'b0, 2'd3,  71, 32'd512,  72, 1,  71,   8'h06};
        vecs[2]  = '{1'b0, 2'd2,  20, 32'd256, 136, 1,  20,   8'h06};
        vecs[3]  = '{1'b0, 2'd0, 168, 32'd1000,168, 2,   0,   8'h1F};
        vecs[4]  = '{1'b0, 2'd1, 200, 32'd77,  136, 2,  64,   8'h1F};
        vecs[5]  = '{1'b0, 2'd3,   3, 32'd512,  72, 1,   3,   8'h06};
        vecs[6]  = '{1'b0, 2'd0, 167, 32'd128, 168, 1, 167,   8'h1F};
        vecs[7]  = '{1'b1, 2'd1, 136, 32'd512, 136, 2,   0,   8'h1F};
        vecs[8]  = '{1'b1, 2'd2,   5, 32'd256, 136, 1,   5,   8'h06};
        vecs[9]  = '{1'b1, 2'd0,   0, 32'd64,  168, 1,   0,   8'h1F};
        vecs[10] = '{1'b1, 2'd3,  71, 32'd512,  72, 1,  71,   8'h06};
        bp       = '{1'b0, 2'd0, 504, 32'd4096,168, 4,   0,   8'h1F};
        rv       = '{1'b0, 2'd0, 300, 32'd99,  168, 2, 132,   8'h1F};

        repeat (3) @(negedge clk);
        #1;
        chk("reset ready_out", r64, 0);
        chk("reset blk_valid", bv64, 0);
        chk("reset blk_last", bl64, 0);
        chk("reset operation_mode", m64, 0);
        chk("reset output_size", os64, 0);
        chk_blk("reset blk_data", bd64, '0);
        chk("reset w32 ready_out", r32, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("ready_out after reset", r64, 1);

        for (int i = 0; i < 11; i++) begin
            q64.delete();
            q32.delete();
            send_msg(vecs[i]);
            idle();
            check_msg(vecs[i], $sformatf("vec%0d", i), 0, vecs[i].nblk);
        end

        // Back-to-back messages of different modes.
        q64.delete();
        send_msg(vecs[1]);
        send_msg(vecs[6]);
        idle();
        check_msg(vecs[1], "b2b first", 0, 2);
        check_msg(vecs[6], "b2b second", 1, 2);

        // Backpressure: two blocks fill the queue, the third block's closing word stalls.
        q64.delete();
        br64 = 1'b0;
        send_hdr(bp);
        for (int k = 0; k < 62; k++) put_word(1'b0, make_word(bp, k));
        @(negedge clk);
        d64 = make_word(bp, 62);
        v64 = 1'b1;
        #1;
        chk("bp blk_valid while full", bv64, 1);
        chk("bp ready drops", r64, 0);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("bp ready held", r64, 0);
        end
        @(negedge clk);
        br64 = 1'b1;
        #1;
        chk("bp ready during pop", r64, 0);
        @(negedge clk);
        br64 = 1'b0;
        #1;
        chk("bp ready reasserts", r64, 1);
        chk("bp exactly one pop", q64.size(), 1);
        idle();
        repeat (4) @(negedge clk);
        chk("bp no pop while held", q64.size(), 1);
        br64 = 1'b1;
        check_msg(bp, "bp", 0, 4);

        // Reset in the middle of a message with one block buffered.
        q64.delete();
        br64 = 1'b0;
        send_hdr(rv);
        for (int k = 0; k < 24; k++) put_word(1'b0, make_word(rv, k));
        @(negedge clk);
        v64 = 1'b0;
        #1;
        chk("rst pre blk_valid", bv64, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst next blk_valid", bv64, 0);
        chk("rst next ready_out", r64, 0);
        @(negedge clk);
        #1;
        chk("rst after ready_out", r64, 1);
        q64.delete();
        br64 = 1'b1;
        send_msg(vecs[2]);
        idle();
        check_msg(vecs[2], "post-rst", 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
